// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of DEPTH valid/ready register stages, WIDTH bits wide.
// Each stage advances when it is empty or when the stage after it is advancing.
// out_valid and out_data come straight from the last stage's registers.
// Optional feature: define PIPE_STAGE_CHAIN_COUNT_EN to add a registered `count`
// output that holds the number of occupied stages.
module pipe_stage_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_CHAIN_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  generate
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $error("pipe_stage_chain: DEPTH must be in 1..16");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("pipe_stage_chain: WIDTH must be in 1..64");
    end
  endgenerate

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];

  // Stage ready. A stage is blocked only when it and every stage after it
  // are full while out_ready is low. Computing that as a running AND avoids a
  // combinational loop through the rdy vector.
  always_comb begin
    logic blocked;
    rdy     = '0;
    blocked = !out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      blocked = blocked & v[i];
      rdy[i]  = !blocked;
    end
  end

  // Next-state valid bits. A ready stage takes whatever its upstream neighbour
  // offers. If the neighbour offers nothing, the stage goes empty. Flush empties
  // every stage, and the word on in_* in that cycle is lost with the rest.
  always_comb begin
    v_next = v;
    if (rdy[0]) v_next[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) v_next[i] = v[i-1];
    end
    if (flush) v_next = '0;
  end

  // Valid and data registers. Reset clears both and overrides flush and any
  // transfer. Data registers load only when a word actually arrives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v <= v_next;
      if (rdy[0] && in_valid) d[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i] && v[i-1]) d[i] <= d[i-1];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

`ifdef PIPE_STAGE_CHAIN_COUNT_EN
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count_next;

  // Occupancy of the next state, so the registered count matches v after each edge.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) count_next = count_next + CW'(v_next[i]);
  end

  // Occupancy register; reset clears it, and flush clears it through v_next.
  always_ff @(posedge clk) begin
    if (!reset) count <= '0;
    else        count <= count_next;
  end
`endif

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages, legal range 1..16; elaboration SHALL fail outside this range.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept in_data this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: stage DEPTH-1 holds valid data.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: payload of stage DEPTH-1.

Function
REQ-012 Each stage i (0..DEPTH-1) SHALL hold one valid bit v[i] and one WIDTH-bit data register d[i]; stage 0 is fed from in_*, stage DEPTH-1 drives out_*.
REQ-013 Stage i SHALL be ready when v[i]=0 or stage i+1 is ready; stage DEPTH-1 SHALL be ready when v[DEPTH-1]=0 or out_ready=1; in_ready SHALL equal stage 0 ready.
REQ-014 A transfer SHALL occur on an edge where valid and ready are both 1 at that interface; on transfer the receiving stage loads data and sets valid; a stage whose data moves on and receives nothing SHALL clear its valid bit.
REQ-015 A stage that is not ready SHALL hold d[i] and v[i] unchanged.
REQ-016 With out_ready held 1, a word accepted at edge N SHALL appear on out_data/out_valid after edge N+DEPTH-1, i.e. latency DEPTH cycles input-to-output register.
REQ-017 Throughput SHALL be one word per cycle when out_ready=1 continuously; no bubbles inserted.
REQ-018 With out_ready=0, the chain SHALL fill to DEPTH words, after which in_ready=0; no word SHALL be lost, duplicated or reordered.
REQ-019 Simultaneous out transfer and in transfer on a full chain SHALL be permitted (in_ready=1 when out_ready=1 and full).
REQ-020 flush=1 SHALL clear all v[i] at the next edge; a word presented on in_* in the flush cycle SHALL be discarded; data registers need not be cleared.
REQ-021 in_ready SHALL NOT depend on in_valid; out_valid and out_data SHALL be register outputs.

Reset
REQ-022 When reset=0 at a rising clk edge, all v[i] SHALL become 0 and all d[i] SHALL become 0.
REQ-023 After reset: out_valid=0, out_data=0, in_ready=1.
REQ-024 Reset SHALL take priority over flush and over any transfer; words in flight at reset SHALL be discarded.

Configuration
REQ-025 Macro PIPE_STAGE_CHAIN_COUNT_EN SHALL, when defined, add output port count, width $clog2(DEPTH+1), equal to the number of set valid bits, registered, 0 after reset or flush.
REQ-026 Without PIPE_STAGE_CHAIN_COUNT_EN the count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 WIDTH=8, DEPTH=3, out_ready=1, stream 0x01..0x0A one per cycle -> 0x01 on out_data 3 cycles after first accept, then 0x02..0x0A consecutively, out_valid high 10 cycles.
REQ-028 DEPTH=3, out_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> in_ready drops after 3 accepts, 0xA4 held upstream; out_ready=1 -> A1,A2,A3,A4 in order, none lost.
REQ-029 Full chain, in_valid=1 and out_ready=1 same cycle with 0x55 -> 0x55 accepted and oldest word emitted in that edge; count stays 3 when COUNT_EN defined.
REQ-030 Two words in flight, flush=1 with in_valid=1 data 0x77 -> out_valid=0 next cycle, 0x77 never emitted, count=0.
REQ-031 reset=0 asserted mid-stream with chain full -> next edge out_valid=0, out_data=0, in_ready=1; reset and flush both asserted behaves as reset.
REQ-032 Random in_valid/out_ready at 50% each, 10,000 words, WIDTH=32, DEPTH=1 and DEPTH=16 -> scoreboard shows in-order, lossless, duplicate-free delivery.
